// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port bank: bus data width, per-channel
// register offsets (byte address bits [4:2]) and an elaboration-time clog2.
package gpio_pkg;

    localparam int unsigned BUS_DW = 32;

    localparam logic [2:0] REG_IN      = 3'd0;
    localparam logic [2:0] REG_OUT     = 3'd1;
    localparam logic [2:0] REG_SET     = 3'd2;
    localparam logic [2:0] REG_CLR     = 3'd3;
    localparam logic [2:0] REG_RISE_EN = 3'd4;
    localparam logic [2:0] REG_FALL_EN = 3'd5;
    localparam logic [2:0] REG_PEND    = 3'd6;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// One GPIO channel's input path: SYNC_STAGES-deep synchroniser chain, a
// previous-value flop, and the derived per-bit edge strobes.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   pin         asynchronous pin inputs for this channel
//   in_sync     last synchroniser stage (the IN register)
//   rise, fall  one-cycle edge strobes: in_sync vs. its value a cycle ago
module gpio_sync_edge #(
    parameter int unsigned CH_WIDTH    = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH_WIDTH-1:0] pin,
    output logic [CH_WIDTH-1:0] in_sync,
    output logic [CH_WIDTH-1:0] rise,
    output logic [CH_WIDTH-1:0] fall
);

    logic [SYNC_STAGES-1:0][CH_WIDTH-1:0] stage;
    logic [CH_WIDTH-1:0]                  prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
            prev  <= '0;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], pin};
            prev  <= stage[SYNC_STAGES-1];
        end
    end

    assign in_sync = stage[SYNC_STAGES-1];
    assign rise    = in_sync & ~prev;
    assign fall    = ~in_sync & prev;

endmodule

// File: rtl/gpio_port_bank.sv
// Memory-mapped GPIO bank: NUM_CH channels of CH_WIDTH bits, each with a
// synchronised input, OUT with set/clear aliases, and per-bit rise/fall
// interrupt pending bits merged into a single registered irq.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus_req, bus_we       one-cycle access request, 1=write
//   bus_addr              byte address: [4:2] register, [ADDR_W-1:5] channel
//   bus_wdata             write data
//   bus_rdata, bus_ack    registered read data / ack, one cycle after bus_req
//   gpio_in               asynchronous pins, channel c at [c*CH_WIDTH +: CH_WIDTH]
//   gpio_out              registered pin outputs
//   irq                   registered OR of PEND & (RISE_EN | FALL_EN)
module gpio_port_bank
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CH_WIDTH    = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bus_req,
    input  logic                       bus_we,
    input  logic [ADDR_W-1:0]          bus_addr,
    input  logic [BUS_DW-1:0]          bus_wdata,
    output logic [BUS_DW-1:0]          bus_rdata,
    output logic                       bus_ack,
    input  logic [NUM_CH*CH_WIDTH-1:0] gpio_in,
    output logic [NUM_CH*CH_WIDTH-1:0] gpio_out,
    output logic                       irq
);

    localparam int unsigned CH_BITS = clog2(NUM_CH);

    if (ADDR_W < 5 + CH_BITS) begin : g_bad_addr_w
        $error("gpio_port_bank: ADDR_W too small for NUM_CH");
    end

    int unsigned         ch_idx;
    logic [2:0]          reg_off;
    logic                ch_ok;
    logic [CH_WIDTH-1:0] wdata_ch;
    logic [BUS_DW-1:0]   rd_acc [NUM_CH+1];
    logic [NUM_CH:0]     irq_acc;
    logic                unused_bits;

    // The whole field above bit 4 is decoded so that out-of-range channel
    // indices never alias onto an existing channel.
    if (ADDR_W > 5) begin : g_ch_field
        assign ch_idx = 32'(bus_addr[ADDR_W-1:5]);
    end else begin : g_no_ch_field
        assign ch_idx = '0;
    end

    assign reg_off     = bus_addr[4:2];
    assign ch_ok       = (ch_idx < NUM_CH) && (reg_off != 3'd7);
    assign wdata_ch    = bus_wdata[CH_WIDTH-1:0];
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    assign rd_acc[0]  = '0;
    assign irq_acc[0] = 1'b0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CH_WIDTH-1:0] in_sync;
        logic [CH_WIDTH-1:0] rise;
        logic [CH_WIDTH-1:0] fall;
        logic [CH_WIDTH-1:0] out_q;
        logic [CH_WIDTH-1:0] rise_en_q;
        logic [CH_WIDTH-1:0] fall_en_q;
        logic [CH_WIDTH-1:0] pend_q;
        logic [CH_WIDTH-1:0] w1c;
        logic                sel;
        logic                wr;
        logic [BUS_DW-1:0]   rd_ch;

        gpio_sync_edge #(
            .CH_WIDTH   (CH_WIDTH),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin    (gpio_in[c*CH_WIDTH +: CH_WIDTH]),
            .in_sync(in_sync),
            .rise   (rise),
            .fall   (fall)
        );

        assign sel = ch_ok && (ch_idx == c);
        assign wr  = bus_req && bus_we && sel;
        assign w1c = (wr && (reg_off == REG_PEND)) ? wdata_ch : '0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q     <= '0;
                rise_en_q <= '0;
                fall_en_q <= '0;
                pend_q    <= '0;
            end else begin
                if (wr) begin
                    case (reg_off)
                        REG_OUT:     out_q     <= wdata_ch;
                        REG_SET:     out_q     <= out_q | wdata_ch;
                        REG_CLR:     out_q     <= out_q & ~wdata_ch;
                        REG_RISE_EN: rise_en_q <= wdata_ch;
                        REG_FALL_EN: fall_en_q <= wdata_ch;
                        default:     ;
                    endcase
                end
                // Clear first, then OR in new edges so a same-cycle edge wins.
                pend_q <= (pend_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
            end
        end

        always_comb begin
            rd_ch = '0;
            if (sel) begin
                case (reg_off)
                    REG_IN:      rd_ch[CH_WIDTH-1:0] = in_sync;
                    REG_OUT:     rd_ch[CH_WIDTH-1:0] = out_q;
                    REG_RISE_EN: rd_ch[CH_WIDTH-1:0] = rise_en_q;
                    REG_FALL_EN: rd_ch[CH_WIDTH-1:0] = fall_en_q;
                    REG_PEND:    rd_ch[CH_WIDTH-1:0] = pend_q;
                    default:     rd_ch = '0;
                endcase
            end
        end

        assign rd_acc[c+1]  = rd_acc[c] | rd_ch;
        assign irq_acc[c+1] = irq_acc[c] | (|(pend_q & (rise_en_q | fall_en_q)));
        assign gpio_out[c*CH_WIDTH +: CH_WIDTH] = out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            bus_ack   <= bus_req;
            bus_rdata <= (bus_req && !bus_we) ? rd_acc[NUM_CH] : '0;
            irq       <= irq_acc[NUM_CH];
        end
    end

endmodule

// File: tb/tb_gpio_port_bank.sv
module tb_gpio_port_bank;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned S      = 2;  // synchroniser depth used by both DUTs

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [7:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata, bus_rdata8;
    logic        bus_ack, bus_ack8;
    logic [63:0] gpio_in = '0;
    logic [63:0] gpio_out;
    logic [15:0] gpio_in8 = '0;
    logic [15:0] gpio_out8;
    logic        irq, irq8;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    gpio_port_bank #(.NUM_CH(2), .CH_WIDTH(32), .SYNC_STAGES(2), .ADDR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
    );

    gpio_port_bank #(.NUM_CH(2), .CH_WIDTH(8), .SYNC_STAGES(2), .ADDR_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata8), .bus_ack(bus_ack8),
        .gpio_in(gpio_in8), .gpio_out(gpio_out8), .irq(irq8)
    );

    // Reference model of the 32-bit bank. m_hist[c][k] is the pin value
    // sampled k+1 edges ago; IN is the pin seen S edges back.
    logic [31:0] m_out  [NUM_CH];
    logic [31:0] m_re   [NUM_CH];
    logic [31:0] m_fe   [NUM_CH];
    logic [31:0] m_pend [NUM_CH];
    logic [31:0] m_hist [NUM_CH][S+2];
    logic        m_irq, m_ack;
    logic [31:0] m_rdata;

    function automatic logic [7:0] addr_of(input int unsigned ch, input int unsigned off);
        return 8'((ch << 5) | (off << 2));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_out[c] = '0; m_re[c] = '0; m_fe[c] = '0; m_pend[c] = '0;
            for (int k = 0; k < S + 2; k++) m_hist[c][k] = '0;
        end
        m_irq = 1'b0; m_ack = 1'b0; m_rdata = '0;
    endtask

    task automatic model_step(input logic req, input logic we, input logic [7:0] addr,
                              input logic [31:0] wdata);
        int unsigned ch;
        int unsigned off;
        bit          ok;
        logic        irq_n;
        logic [31:0] rd, w1c, cur, old;
        ch  = int'(addr[7:5]);
        off = int'(addr[4:2]);
        ok  = (ch < NUM_CH) && (off != 7);
        irq_n = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if ((m_pend[c] & (m_re[c] | m_fe[c])) != 0) irq_n = 1'b1;
        rd = '0;
        if (ok) begin
            case (off)
                0: rd = m_hist[ch][S-1];
                1: rd = m_out[ch];
                4: rd = m_re[ch];
                5: rd = m_fe[ch];
                6: rd = m_pend[ch];
                default: rd = '0;
            endcase
        end
        for (int c = 0; c < NUM_CH; c++) begin
            w1c = (req && we && ok && ch == c && off == 6) ? wdata : '0;
            cur = m_hist[c][S-1];
            old = m_hist[c][S];
            m_pend[c] = (m_pend[c] & ~w1c) | (cur & ~old & m_re[c]) | (~cur & old & m_fe[c]);
        end
        if (req && we && ok) begin
            case (off)
                1: m_out[ch] = wdata;
                2: m_out[ch] = m_out[ch] | wdata;
                3: m_out[ch] = m_out[ch] & ~wdata;
                4: m_re[ch]  = wdata;
                5: m_fe[ch]  = wdata;
                default: ;
            endcase
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = S + 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
            m_hist[c][0] = gpio_in[c*32 +: 32];
        end
        m_ack   = req;
        m_rdata = (req && !we) ? rd : '0;
        m_irq   = irq_n;
    endtask

    // One clock: drive a bus request, let the edge pass, advance the model.
    task automatic bus_cycle(input logic req, input logic we, input logic [7:0] addr,
                             input logic [31:0] wdata);
        bus_req = req; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        @(posedge clk);
        #1;
        model_step(req, we, addr, wdata);
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        bus_cycle(1'b1, 1'b1, addr_of(0, 1), 32'h0000_A5A5);
        bus_cycle(1'b1, 1'b1, addr_of(0, 4), 32'h1);
        gpio_in[0] = 1'b1;
        idle(4);
        bus_cycle(1'b1, 1'b0, addr_of(0, 1), 32'h0);
        n_checks++;
        if (bus_ack !== 1'b1 || bus_rdata !== 32'h0000_A5A5 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got ack=%b rdata=%h irq=%b expected ack=1 rdata=0000a5a5 irq=1",
                     bus_ack, bus_rdata, irq);
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (gpio_out !== 64'h0 || irq !== 1'b0 || bus_ack !== 1'b0 || bus_rdata !== 32'h0 ||
            gpio_out8 !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: got out=%h irq=%b ack=%b rdata=%h out8=%h expected all 0",
                     gpio_out, irq, bus_ack, bus_rdata, gpio_out8);
        end
        gpio_in = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned o = 0; o < 8; o++) begin
                bus_cycle(1'b1, 1'b0, addr_of(c, o), 32'h0);
                n_checks++;
                if (bus_ack !== 1'b1 || bus_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_read ch%0d off%0d: got ack=%b rdata=%h expected ack=1 rdata=0",
                             c, o, bus_ack, bus_rdata);
                end
            end
        end
    endtask

    task automatic test_output_path();
        bus_cycle(1'b1, 1'b1, addr_of(0, 1), 32'h0000_00F0);
        n_checks++;
        if (gpio_out[31:0] !== 32'hF0) begin
            n_fail++; $display("FAIL out_write: got %h expected 000000f0", gpio_out[31:0]);
        end
        bus_cycle(1'b1, 1'b1, addr_of(0, 2), 32'h0000_000F);
        n_checks++;
        if (gpio_out[31:0] !== 32'hFF) begin
            n_fail++; $display("FAIL out_set: got %h expected 000000ff", gpio_out[31:0]);
        end
        bus_cycle(1'b1, 1'b1, addr_of(0, 3), 32'h0000_0081);
        n_checks++;
        if (gpio_out[31:0] !== 32'h7E) begin
            n_fail++; $display("FAIL out_clr: got %h expected 0000007e", gpio_out[31:0]);
        end
        bus_cycle(1'b1, 1'b0, addr_of(0, 1), 32'h0);
        n_checks++;
        if (bus_ack !== 1'b1 || bus_rdata !== 32'h7E) begin
            n_fail++;
            $display("FAIL out_read: got ack=%b rdata=%h expected ack=1 rdata=0000007e", bus_ack, bus_rdata);
        end
        idle(1);
        n_checks++;
        if (bus_ack !== 1'b0 || bus_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL ack_single: got ack=%b rdata=%h expected ack=0 rdata=0", bus_ack, bus_rdata);
        end
    endtask

    task automatic test_rise_irq();
        bus_cycle(1'b1, 1'b1, addr_of(1, 4), 32'h1);
        gpio_in[32] = 1'b1;
        idle(2);                                   // E1, E2
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL rise_e2_irq: got %b expected 0", irq);
        end
        bus_cycle(1'b1, 1'b0, addr_of(1, 0), 32'h0); // E3 returns IN as updated at E2
        n_checks++;
        if (bus_rdata !== 32'h1 || irq !== 1'b0) begin
            n_fail++; $display("FAIL rise_in: got rdata=%h irq=%b expected rdata=1 irq=0", bus_rdata, irq);
        end
        bus_cycle(1'b1, 1'b0, addr_of(1, 6), 32'h0); // E4 returns PEND as set at E3
        n_checks++;
        if (bus_rdata !== 32'h1 || irq !== 1'b1) begin
            n_fail++; $display("FAIL rise_pend: got rdata=%h irq=%b expected rdata=1 irq=1", bus_rdata, irq);
        end
        bus_cycle(1'b1, 1'b1, addr_of(1, 6), 32'h1);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL w1c_irq_hold: got %b expected 1", irq);
        end
        idle(1);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL w1c_irq_clear: got %b expected 0", irq);
        end
    endtask

    task automatic test_collision();
        bus_cycle(1'b1, 1'b1, addr_of(0, 5), 32'h8);
        gpio_in[3] = 1'b1;
        idle(4);
        gpio_in[3] = 1'b0;
        idle(4);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL coll_setup_irq: got %b expected 1", irq);
        end
        gpio_in[3] = 1'b1;
        idle(4);
        gpio_in[3] = 1'b0;
        idle(2);
        bus_cycle(1'b1, 1'b1, addr_of(0, 6), 32'h8); // falls on the edge that applies the fall
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL coll_irq: got %b expected 1", irq);
        end
        bus_cycle(1'b1, 1'b0, addr_of(0, 6), 32'h0);
        n_checks++;
        if (bus_rdata !== 32'h8 || irq !== 1'b1) begin
            n_fail++; $display("FAIL coll_pend: got rdata=%h irq=%b expected rdata=8 irq=1", bus_rdata, irq);
        end
    endtask

    task automatic test_unmapped();
        logic [63:0] exp_out;
        logic [63:0] pins;
        exp_out = {m_out[1], m_out[0]};
        bus_cycle(1'b1, 1'b1, addr_of(3, 1), 32'hDEAD_BEEF);
        n_checks++;
        if (bus_ack !== 1'b1 || gpio_out !== exp_out) begin
            n_fail++; $display("FAIL unmapped_ch_wr: got ack=%b out=%h expected ack=1 out=%h", bus_ack, gpio_out, exp_out);
        end
        bus_cycle(1'b1, 1'b1, addr_of(0, 7), 32'hDEAD_BEEF);
        n_checks++;
        if (bus_ack !== 1'b1 || gpio_out !== exp_out) begin
            n_fail++; $display("FAIL unmapped_off_wr: got ack=%b out=%h expected ack=1 out=%h", bus_ack, gpio_out, exp_out);
        end
        bus_cycle(1'b1, 1'b0, addr_of(3, 1), 32'h0);
        n_checks++;
        if (bus_ack !== 1'b1 || bus_rdata !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_ch_rd: got ack=%b rdata=%h expected ack=1 rdata=0", bus_ack, bus_rdata);
        end
        bus_cycle(1'b1, 1'b0, addr_of(0, 7), 32'h0);
        n_checks++;
        if (bus_ack !== 1'b1 || bus_rdata !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_off_rd: got ack=%b rdata=%h expected ack=1 rdata=0", bus_ack, bus_rdata);
        end
        bus_cycle(1'b1, 1'b0, addr_of(1, 1), 32'h0);
        n_checks++;
        if (bus_rdata !== 32'h0) begin
            n_fail++; $display("FAIL alias_out_ch1: got %h expected 0", bus_rdata);
        end
        pins = {$urandom, $urandom};
        gpio_in = pins;
        idle(3);
        bus_cycle(1'b1, 1'b0, addr_of(0, 0), 32'h0);
        n_checks++;
        if (bus_ack !== 1'b1 || bus_rdata !== pins[31:0]) begin
            n_fail++; $display("FAIL b2b_in_ch0: got ack=%b rdata=%h expected ack=1 rdata=%h", bus_ack, bus_rdata, pins[31:0]);
        end
        bus_cycle(1'b1, 1'b0, addr_of(1, 0), 32'h0);
        n_checks++;
        if (bus_ack !== 1'b1 || bus_rdata !== pins[63:32]) begin
            n_fail++; $display("FAIL b2b_in_ch1: got ack=%b rdata=%h expected ack=1 rdata=%h", bus_ack, bus_rdata, pins[63:32]);
        end
    endtask

    task automatic test_width();
        logic [7:0] ch1_exp;
        ch1_exp = m_out[1][7:0];
        bus_cycle(1'b1, 1'b1, addr_of(0, 1), 32'hFFFF_FFFF);
        n_checks++;
        if (gpio_out8 !== {ch1_exp, 8'hFF}) begin
            n_fail++; $display("FAIL width_out: got %h expected %h", gpio_out8, {ch1_exp, 8'hFF});
        end
        bus_cycle(1'b1, 1'b0, addr_of(0, 1), 32'h0);
        n_checks++;
        if (bus_rdata8 !== 32'h0000_00FF || bus_ack8 !== 1'b1) begin
            n_fail++; $display("FAIL width_read: got ack=%b rdata=%h expected ack=1 rdata=000000ff", bus_ack8, bus_rdata8);
        end
        n_checks++;
        if (bus_rdata !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL width_read32: got %h expected ffffffff", bus_rdata);
        end
    endtask

    task automatic test_random();
        logic        req, we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [63:0] exp_out;
        for (int unsigned i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                gpio_in = gpio_in ^ {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
            req   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1) == 1;
            addr  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
            wdata = $urandom;
            bus_cycle(req, we, addr, wdata);
            exp_out = {m_out[1], m_out[0]};
            n_checks++;
            if (gpio_out !== exp_out) begin
                n_fail++; $display("FAIL rnd_out[%0d]: got %h expected %h", i, gpio_out, exp_out);
            end
            n_checks++;
            if (bus_ack !== m_ack || bus_rdata !== m_rdata) begin
                n_fail++;
                $display("FAIL rnd_bus[%0d]: got ack=%b rdata=%h expected ack=%b rdata=%h",
                         i, bus_ack, bus_rdata, m_ack, m_rdata);
            end
            n_checks++;
            if (irq !== m_irq) begin
                n_fail++; $display("FAIL rnd_irq[%0d]: got %b expected %b", i, irq, m_irq);
            end
            n_checks++;
            if (gpio_out8 !== {m_out[1][7:0], m_out[0][7:0]}) begin
                n_fail++;
                $display("FAIL rnd_out8[%0d]: got %h expected %h", i, gpio_out8, {m_out[1][7:0], m_out[0][7:0]});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_output_path();
        test_rise_irq();
        test_collision();
        test_unmapped();
        test_width();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
